// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU bus adapter.
// Holds the FSM state, the funct3 encodings, and the lane/enable/legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] lsu_be(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lsu_lanes(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] lanes;
    lanes = wd;
    unique case (f3[1:0])
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  // Stores only have signed encodings; BU/HU are load-only.
  function automatic logic lsu_bad(
    input logic       re,
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic legal;
    logic mis;
    legal = 1'b0;
    unique case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;
      default:          legal = 1'b0;
    endcase
    mis = (f3[1:0] == 2'b01 && off[0]) ||
          (f3[1:0] == 2'b10 && off != 2'b00);
    return (re & we) | !legal | mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: moves the addressed lane to bit 0
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata_q,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_rdata
);

  logic [31:0] w_sh;

  assign w_sh = i_rdata_q >> {i_off, 3'b000};

  always_comb begin
    o_rdata = w_sh;
    unique case (i_f3)
      F3_B:    o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_BU:   o_rdata = {24'd0, w_sh[7:0]};
      F3_H:    o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_HU:   o_rdata = {16'd0, w_sh[15:0]};
      default: o_rdata = w_sh;
    endcase
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Turns single-cycle datapath loads/stores into req/ack bus transactions,
// stalling the core until the access completes, faults, or times out.
module lsu_bus_adapter
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata_q;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [CW-1:0] r_cnt;
  logic        r_err;

  logic        w_access;
  logic        w_fault_c;
  logic [31:0] w_align;

  assign w_access  = mem_re | mem_we;
  assign w_fault_c = w_access &
                     lsu_bad(mem_re, mem_we, funct3, addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_rdata_q   <= 32'd0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_access && !w_fault_c) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= lsu_be(funct3, addr[1:0]);
            r_bus_wdata <= lsu_lanes(funct3, wdata);
            r_f3        <= funct3;
            r_off       <= addr[1:0];
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_state     <= REQ;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus_ack) begin
            r_rdata_q <= bus_rdata;
            r_bus_req <= 1'b0;
            r_state   <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata_q <= 32'd0;
            r_err     <= 1'b1;
            r_bus_req <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  lsu_load_align u_align (
    .i_rdata_q (r_rdata_q),
    .i_off     (r_off),
    .i_f3      (r_f3),
    .o_rdata   (w_align)
  );

  always_comb begin
    stall   = 1'b0;
    fault   = 1'b0;
    bus_err = 1'b0;
    rdata   = 32'd0;
    unique case (r_state)
      IDLE: begin
        fault = w_fault_c;
        stall = w_access & !w_fault_c;
      end
      REQ:  stall = 1'b1;
      DONE: begin
        rdata   = w_align;
        bus_err = r_err;
      end
      default: stall = 1'b0;
    endcase
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: loads, stores, faults,
// timeout and reset mid-transaction, with hand-computed expectations.
module tb_lsu_bus_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_bus_adapter dut (
    .clk       (clk),
    .reset     (reset),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .fault     (fault),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_re = 0; mem_we = 0; funct3 = 0;
    addr = 0; wdata = 0; bus_ack = 0; bus_rdata = 0;
  endtask

  // One load with ack in the first REQ cycle.
  task automatic run_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] brd,
                          input logic [3:0] be, input logic [31:0] exp);
    mem_re = 1; funct3 = f3; addr = a;
    #1;
    chk({tag, "_stall_idle"}, 32'(stall), 32'd1);
    cyc();
    #1;
    chk({tag, "_req"}, 32'(bus_req), 32'd1);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, 32'(bus_be), 32'(be));
    chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    bus_ack = 1; bus_rdata = brd;
    cyc();
    bus_ack = 0; bus_rdata = 32'h5555_5555;
    #1;
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_req_done"}, 32'(bus_req), 32'd0);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_err"}, 32'(bus_err), 32'd0);
    cyc();
    idle_in();
    #1;
    chk({tag, "_rdata_idle"}, rdata, 32'd0);
  endtask

  int n;

  initial begin
    idle_in();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    cyc();
    run_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    cyc();
    run_load("lb", 3'b000, 32'h103, 32'h80112233, 4'b1000, 32'hFFFFFF80);
    cyc();
    run_load("lbu", 3'b100, 32'h103, 32'h80112233, 4'b1000, 32'h00000080);
    cyc();
    run_load("lh", 3'b001, 32'h102, 32'h8001_7FFF, 4'b1100, 32'hFFFF8001);
    cyc();
    run_load("lhu", 3'b101, 32'h102, 32'h8001_7FFF, 4'b1100, 32'h00008001);
    cyc();
    run_load("lb1", 3'b000, 32'h101, 32'h0000_7F00, 4'b0010, 32'h0000007F);

    // SH store
    cyc();
    mem_we = 1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h0000ABCD;
    cyc();
    #1;
    chk("sh_req", 32'(bus_req), 32'd1);
    chk("sh_we", 32'(bus_we), 32'd1);
    chk("sh_addr", bus_addr, 32'h200);
    chk("sh_be", 32'(bus_be), 32'b1100);
    chk("sh_wdata", bus_wdata, 32'hABCDABCD);
    bus_ack = 1;
    cyc();
    bus_ack = 0;
    #1;
    chk("sh_stall_done", 32'(stall), 32'd0);
    cyc();
    idle_in();

    // SB store lane replication
    cyc();
    mem_we = 1; funct3 = 3'b000; addr = 32'h301; wdata = 32'h1234_56A5;
    cyc();
    #1;
    chk("sb_be", 32'(bus_be), 32'b0010);
    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    bus_ack = 1;
    cyc();
    bus_ack = 0;
    cyc();
    idle_in();

    // Faults
    cyc();
    mem_re = 1; funct3 = 3'b010; addr = 32'h101;
    #1;
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_rdata", rdata, 32'd0);
    cyc();
    idle_in();
    #1;
    chk("mis_req", 32'(bus_req), 32'd0);
    chk("mis_fault_off", 32'(fault), 32'd0);
    mem_re = 1; funct3 = 3'b011; addr = 32'h100;
    #1;
    chk("f3_fault", 32'(fault), 32'd1);
    cyc();
    idle_in();
    #1;
    chk("f3_req", 32'(bus_req), 32'd0);
    mem_re = 1; mem_we = 1; funct3 = 3'b010; addr = 32'h100;
    #1;
    chk("rw_fault", 32'(fault), 32'd1);
    cyc();
    idle_in();
    mem_we = 1; funct3 = 3'b100; addr = 32'h100;
    #1;
    chk("sbu_fault", 32'(fault), 32'd1);
    cyc();
    idle_in();
    #1;
    chk("sbu_req", 32'(bus_req), 32'd0);

    // Timeout: REQ must last exactly 256 cycles
    mem_re = 1; funct3 = 3'b010; addr = 32'h400;
    cyc();
    n = 0;
    while (bus_req === 1'b1 && n < 400) begin
      n++;
      cyc();
    end
    chk("to_cycles", 32'(n), 32'd256);
    #1;
    chk("to_err", 32'(bus_err), 32'd1);
    chk("to_rdata", rdata, 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    cyc();
    idle_in();
    #1;
    chk("to_err_off", 32'(bus_err), 32'd0);

    // Reset during second REQ cycle
    cyc();
    mem_re = 1; funct3 = 3'b010; addr = 32'h500;
    cyc();
    cyc();
    #1;
    chk("rr_req2", 32'(bus_req), 32'd1);
    reset = 1; mem_re = 0;
    cyc();
    reset = 0;
    #1;
    chk("rr_req_low", 32'(bus_req), 32'd0);
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    cyc();
    bus_ack = 0;
    #1;
    chk("rr_late_req", 32'(bus_req), 32'd0);
    chk("rr_late_stall", 32'(stall), 32'd0);
    chk("rr_late_rdata", rdata, 32'd0);
    cyc();
    #1;
    chk("rr_idle_rdata", rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
